// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared constants for the stream demultiplexer and its per-output slots.
//   CNT_WIDTH      : width of the per-output accepted-transfer counters
//   DEFAULT_WIDTH  : default data width of I / O0 / O1
//   DEFAULT_SWIDTH : default width of the route select S
// -----------------------------------------------------------------------------
package stream_demux_pkg;

    localparam int CNT_WIDTH      = 8;
    localparam int DEFAULT_WIDTH  = 1;
    localparam int DEFAULT_SWIDTH = 1;

endpackage : stream_demux_pkg

// File: rtl/stream_demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry output buffer for one demux output, plus its transfer counter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : a transfer is accepted into this slot this cycle
//   din        : data to load
//   out_ready  : downstream consumer ready
//   dout       : registered slot data
//   out_valid  : registered slot valid
//   cnt        : number of transfers loaded into this slot, modulo 2**CNT_WIDTH
//   can_load   : slot is empty, or will be drained this cycle
// -----------------------------------------------------------------------------
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     din,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     dout,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 can_load
);

    logic [WIDTH-1:0]     data_r;
    logic                 valid_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    // Slot state: load wins over drain so a simultaneous drain+fill keeps valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            cnt_r   <= '0;
        end else if (load) begin
            data_r  <= din;
            valid_r <= 1'b1;
            cnt_r   <= cnt_r + CNT_WIDTH'(1);
        end else if (valid_r && out_ready) begin
            // Drained with no refill: data is kept but no longer valid.
            data_r  <= data_r;
            valid_r <= 1'b0;
            cnt_r   <= cnt_r;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
            cnt_r   <= cnt_r;
        end
    end

    // Space is available when empty or when the held entry leaves this cycle.
    always_comb begin
        can_load = 1'b0;
        if (!valid_r || out_ready) begin
            can_load = 1'b1;
        end else begin
            can_load = 1'b0;
        end
    end

    assign dout      = data_r;
    assign out_valid = valid_r;
    assign cnt       = cnt_r;

endmodule : demux_slot

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// Routes a valid/ready input stream to one of two buffered outputs.
// S == 0 selects output 0, any nonzero S selects output 1. Each output has its
// own one-entry slot, so a stall on one output never blocks traffic bound for
// the other.
// Ports:
//   CLK, RESET            : clock, synchronous active-high reset
//   I, I_valid, I_ready   : input stream (I_ready combinational in S, On_ready)
//   S                     : route select, sampled together with I
//   O0, O0_valid, O0_ready: output 0 stream (data/valid registered)
//   O1, O1_valid, O1_ready: output 1 stream (data/valid registered)
//   CNT0, CNT1            : transfers accepted toward each output, mod 256
// -----------------------------------------------------------------------------
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SWIDTH = DEFAULT_SWIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     I,
    input  logic                 I_valid,
    output logic                 I_ready,
    input  logic [SWIDTH-1:0]    S,
    output logic [WIDTH-1:0]     O0,
    output logic                 O0_valid,
    input  logic                 O0_ready,
    output logic [WIDTH-1:0]     O1,
    output logic                 O1_valid,
    input  logic                 O1_ready,
    output logic [CNT_WIDTH-1:0] CNT0,
    output logic [CNT_WIDTH-1:0] CNT1
);

    // Any set bit in the select steers to output 1.
    function automatic logic select_route(input logic [SWIDTH-1:0] sel);
        return |sel;
    endfunction

    logic route_s;
    logic sel_can_load_s;
    logic can_load0_s;
    logic can_load1_s;
    logic accept_s;
    logic load0_s;
    logic load1_s;

    // Input handshake: only the selected slot's occupancy gates the input.
    always_comb begin
        route_s        = select_route(S);
        sel_can_load_s = 1'b0;
        case (route_s)
            1'b0:    sel_can_load_s = can_load0_s;
            1'b1:    sel_can_load_s = can_load1_s;
            default: sel_can_load_s = 1'b0;
        endcase
        I_ready  = !RESET && sel_can_load_s;
        accept_s = I_valid && I_ready;
        load0_s  = accept_s && !route_s;
        load1_s  = accept_s && route_s;
    end

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot0 (
        .clk       (CLK),
        .reset     (RESET),
        .load      (load0_s),
        .din       (I),
        .out_ready (O0_ready),
        .dout      (O0),
        .out_valid (O0_valid),
        .cnt       (CNT0),
        .can_load  (can_load0_s)
    );

    demux_slot #(
        .WIDTH (WIDTH)
    ) u_slot1 (
        .clk       (CLK),
        .reset     (RESET),
        .load      (load1_s),
        .din       (I),
        .out_ready (O1_ready),
        .dout      (O1),
        .out_valid (O1_valid),
        .cnt       (CNT1),
        .can_load  (can_load1_s)
    );

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
// Directed, table-driven bench for stream_demux. A WIDTH=8/SWIDTH=1 instance
// runs a vector table plus a counter-wrap sequence; a WIDTH=8/SWIDTH=4 instance
// checks multi-bit select routing.
// -----------------------------------------------------------------------------
module tb_stream_demux;

    logic       CLK = 1'b0;
    logic       RESET;

    // SWIDTH=1 instance
    logic [7:0] i_d;
    logic       iv_d;
    logic       ir_d;
    logic       s_d;
    logic [7:0] o0_d, o1_d;
    logic       v0_d, v1_d;
    logic       r0_d, r1_d;
    logic [7:0] c0_d, c1_d;

    // SWIDTH=4 instance
    logic [7:0] i_w;
    logic       iv_w;
    logic       ir_w;
    logic [3:0] s_w;
    logic [7:0] o0_w, o1_w;
    logic       v0_w, v1_w;
    logic       r0_w, r1_w;
    logic [7:0] c0_w, c1_w;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    stream_demux #(.WIDTH(8), .SWIDTH(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .I(i_d), .I_valid(iv_d), .I_ready(ir_d), .S(s_d),
        .O0(o0_d), .O0_valid(v0_d), .O0_ready(r0_d),
        .O1(o1_d), .O1_valid(v1_d), .O1_ready(r1_d),
        .CNT0(c0_d), .CNT1(c1_d)
    );

    stream_demux #(.WIDTH(8), .SWIDTH(4)) dut_w (
        .CLK(CLK), .RESET(RESET),
        .I(i_w), .I_valid(iv_w), .I_ready(ir_w), .S(s_w),
        .O0(o0_w), .O0_valid(v0_w), .O0_ready(r0_w),
        .O1(o1_w), .O1_valid(v1_w), .O1_ready(r1_w),
        .CNT0(c0_w), .CNT1(c1_w)
    );

    typedef struct {
        logic       rst;
        logic [7:0] i;
        logic       iv;
        logic       s;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic [7:0] e_o0;
        logic       e_v0;
        logic [7:0] e_o1;
        logic       e_v1;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [7:0] e_o0, input logic e_v0,
                                 input logic [7:0] e_o1, input logic e_v1,
                                 input logic [7:0] e_c0, input logic [7:0] e_c1);
        check("O0", idx, o0_d, e_o0);
        check("O0_valid", idx, {7'd0, v0_d}, {7'd0, e_v0});
        check("O1", idx, o1_d, e_o1);
        check("O1_valid", idx, {7'd0, v1_d}, {7'd0, e_v1});
        check("CNT0", idx, c0_d, e_c0);
        check("CNT1", idx, c1_d, e_c1);
    endtask

    initial begin
        //              rst   i      iv    s     r0    r1    rdy   o0     v0    o1     v1    c0     c1
        vecs[0]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0, 8'd0};
        vecs[1]  = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 8'd1, 8'd0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'd2, 8'd0};
        vecs[3]  = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd2, 8'd0};
        vecs[4]  = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 1'b1, 8'd2, 8'd1};
        vecs[5]  = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'd2, 8'd1};
        vecs[6]  = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h01, 1'b1, 8'd3, 8'd1};
        vecs[7]  = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 8'h01, 1'b1, 8'd3, 8'd1};
        vecs[8]  = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 8'd3, 8'd2};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h44, 1'b0, 8'd3, 8'd2};
        vecs[10] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h44, 1'b0, 8'd4, 8'd2};
        vecs[11] = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'd4, 8'd3};
        vecs[12] = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0, 8'd0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0, 8'd0};

        RESET = 1'b1;
        i_d = 8'h00; iv_d = 1'b0; s_d = 1'b0; r0_d = 1'b0; r1_d = 1'b0;
        i_w = 8'h00; iv_w = 1'b0; s_w = 4'd0; r0_w = 1'b0; r1_w = 1'b0;

        // Table: inputs set mid-cycle, I_ready checked before the edge,
        // registered outputs checked just after it.
        for (int k = 0; k < 14; k++) begin
            @(negedge CLK);
            RESET = vecs[k].rst;
            i_d   = vecs[k].i;
            iv_d  = vecs[k].iv;
            s_d   = vecs[k].s;
            r0_d  = vecs[k].r0;
            r1_d  = vecs[k].r1;
            #1;
            check("I_ready", k, {7'd0, ir_d}, {7'd0, vecs[k].e_rdy});
            @(posedge CLK);
            #1;
            check_outputs(k, vecs[k].e_o0, vecs[k].e_v0, vecs[k].e_o1, vecs[k].e_v1,
                          vecs[k].e_c0, vecs[k].e_c1);
        end

        // 256 back-to-back transfers to output 0: CNT0 wraps, CNT1 untouched.
        for (int k = 0; k < 256; k++) begin
            @(negedge CLK);
            RESET = 1'b0;
            i_d   = 8'(k);
            iv_d  = 1'b1;
            s_d   = 1'b0;
            r0_d  = 1'b1;
            r1_d  = 1'b0;
            #1;
            if (ir_d !== 1'b1) begin
                check("wrap_I_ready", k, {7'd0, ir_d}, 8'd1);
            end
            @(posedge CLK);
            #1;
            if (k == 254) begin
                check("CNT0_pre_wrap", k, c0_d, 8'd255);
            end
        end
        check_outputs(300, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd0, 8'd0);
        @(negedge CLK);
        iv_d = 1'b0;

        // Multi-bit select: 4'b0100 goes to output 1, 4'b0000 to output 0.
        @(negedge CLK);
        i_w = 8'hA5; s_w = 4'b0100; iv_w = 1'b1; r0_w = 1'b0; r1_w = 1'b0;
        #1;
        check("W_I_ready", 400, {7'd0, ir_w}, 8'd1);
        @(posedge CLK);
        #1;
        check("W_O1", 400, o1_w, 8'hA5);
        check("W_O1_valid", 400, {7'd0, v1_w}, 8'd1);
        check("W_O0_valid", 400, {7'd0, v0_w}, 8'd0);
        check("W_CNT1", 400, c1_w, 8'd1);
        @(negedge CLK);
        i_w = 8'h5A; s_w = 4'b0000; iv_w = 1'b1;
        @(posedge CLK);
        #1;
        check("W_O0", 401, o0_w, 8'h5A);
        check("W_O0_valid", 401, {7'd0, v0_w}, 8'd1);
        check("W_CNT0", 401, c0_w, 8'd1);
        check("W_O1_hold", 401, o1_w, 8'hA5);
        check("W_CNT1_hold", 401, c1_w, 8'd1);
        @(negedge CLK);
        iv_w = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stream_demux
